call_stack: RTL

//  Parametrised return-address stack for the CPU datapath; successor to the fixed subroutine stack.

---
 rtl/call_stack_pkg.sv | 25 ++
 rtl/call_stack_if.sv | 30 +++
 rtl/call_stack_stack_regs.sv | 24 ++
 rtl/call_stack.sv | 103 ++++++++++
 4 files changed

// File: rtl/call_stack_pkg.sv
// Shared return-address stack types: PC width and push/pop operation decode.
// Combinational helpers only; no state, no flow control.
package call_stack_pkg;

  localparam int PC_WIDTH = 10;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    stack_op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// Control/status bundle between control unit and return-address stack.
// Master drives push/pop/flush/enable; slave returns top entry and status.
interface call_stack_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  enable;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] top_data;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output enable, flush, push, pop, in_data,
    input  top_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  enable, flush, push, pop, in_data,
    output top_data, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack_stack_regs.sv
// DEPTH x AW storage, one synchronous write port and one combinational read port.
// Zero read latency; no reset, no flow control.
module stack_regs #(
  parameter int AW    = 10,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [AW-1:0] i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [AW-1:0] o_rdata
);

  logic [AW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack with occupancy, full/empty, sticky overflow/underflow, replace-top and flush.
// top_data is combinational (zero latency); updates only on enabled clock edges, no backpressure.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_WIDTH,
  parameter int DEPTH      = 16
) (
  input logic         clk,
  input logic         reset,
  call_stack_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  stack_op_e             w_op;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_we;
  logic [IW-1:0]         w_top_idx;
  logic [IW-1:0]         w_waddr;
  logic [ADDR_WIDTH-1:0] w_rdata;

  assign w_op      = decode_op(bus.push, bus.pop);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  // Index is forced to 0 when empty so the read never leaves the array.
  assign w_top_idx = w_empty ? '0 : IW'(r_count - CW'(1));

  always_comb begin
    w_we    = 1'b0;
    w_waddr = IW'(r_count);
    if (bus.enable && !bus.flush) begin
      case (w_op)
        OP_PUSH: w_we = !w_full;
        OP_REPLACE: begin
          w_we    = 1'b1;
          w_waddr = w_top_idx;
        end
        default: ;
      endcase
    end
  end

  stack_regs #(
    .AW    (ADDR_WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_regs (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus.in_data),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.enable) begin
      if (bus.flush) begin
        r_count     <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        case (w_op)
          OP_PUSH: begin
            if (w_full) r_overflow <= 1'b1;
            else        r_count    <= r_count + CW'(1);
          end
          OP_POP: begin
            if (w_empty) r_underflow <= 1'b1;
            else         r_count     <= r_count - CW'(1);
          end
          OP_REPLACE: begin
            // Replace on an empty stack degrades to a push but is still flagged.
            if (w_empty) begin
              r_count     <= CW'(1);
              r_underflow <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
  assign bus.top_data  = w_empty ? '0 : w_rdata;

endmodule
